// File: rtl/fpmult_unpack.sv
// Two-stage operand unpack front end for a binary16 multiplier: registers the raw
// pair, then decodes sign/exponent/mantissa/special flags. Optional: FPMULT_DENORM_EN.
`ifndef DWIDTH
`define DWIDTH 16
`endif
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif

module fpmult_unpack (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [`DWIDTH-1:0]     a,
  input  logic [`DWIDTH-1:0]     b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sa,
  output logic                   sb,
  output logic                   sp,
  output logic [`EXPONENT-1:0]   ea,
  output logic [`EXPONENT-1:0]   eb,
  output logic [`MANTISSA:0]     ma,
  output logic [`MANTISSA:0]     mb,
  output logic [`EXPONENT+1:0]   esum,
  output logic                   za,
  output logic                   zb,
  output logic [4:0]             input_exc
);
  localparam int EW   = `EXPONENT;
  localparam int MW   = `MANTISSA;
  localparam int DW   = `DWIDTH;
  localparam int BIAS = 15;

  typedef struct packed {
    logic [EW-1:0] e;
    logic [MW:0]   m;
    logic          zero;
    logic          inf;
    logic          nan;
  } op_t;

  // Handshake: a pair transfers on in_valid & in_ready, a result on out_valid & out_ready.
  // Both stages move together only when the output slot is empty or being drained.
  logic            w_adv;
  logic            r_s1_valid;
  logic [DW-1:0]   r_s1_a;
  logic [DW-1:0]   r_s1_b;
  op_t             w_da;
  op_t             w_db;
  logic [EW+1:0]   w_esum;
  logic [4:0]      w_exc;

  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;

  function automatic op_t decode_op(input logic [DW-1:0] x);
    logic [EW-1:0] f;
    logic [MW-1:0] fr;
    op_t           d;
    f  = x[DW-2 -: EW];
    fr = x[MW-1:0];
    d  = '0;
    if (f == '1) begin
      // Inf carries {1, 0}, NaN keeps its payload behind the hidden bit.
      d.e   = f;
      d.m   = {1'b1, fr};
      d.inf = (fr == '0);
      d.nan = (fr != '0);
    end else if (f == '0) begin
      if (fr == '0) begin
        d.zero = 1'b1;
      end else begin
`ifdef FPMULT_DENORM_EN
        d.e = EW'(1);
        d.m = {1'b0, fr};
`else
        d.zero = 1'b1;
`endif
      end
    end else begin
      d.e = f;
      d.m = {1'b1, fr};
    end
    return d;
  endfunction

  assign w_da   = decode_op(r_s1_a);
  assign w_db   = decode_op(r_s1_b);
  // Two guard bits make the modular sum exact for the full -15..47 span.
  assign w_esum = {2'b00, w_da.e} + {2'b00, w_db.e} - (EW+2)'(BIAS);
  assign w_exc  = {w_da.nan | w_db.nan | (w_da.inf & w_db.zero) | (w_db.inf & w_da.zero),
                   w_da.nan, w_db.nan, w_da.inf, w_db.inf};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_a     <= a;
      r_s1_b     <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      sp        <= 1'b0;
      ea        <= '0;
      eb        <= '0;
      ma        <= '0;
      mb        <= '0;
      esum      <= '0;
      za        <= 1'b0;
      zb        <= 1'b0;
      input_exc <= '0;
    end else if (w_adv) begin
      out_valid <= r_s1_valid;
      sa        <= r_s1_a[DW-1];
      sb        <= r_s1_b[DW-1];
      sp        <= r_s1_a[DW-1] ^ r_s1_b[DW-1];
      ea        <= w_da.e;
      eb        <= w_db.e;
      ma        <= w_da.m;
      mb        <= w_db.m;
      esum      <= w_esum;
      za        <= w_da.zero;
      zb        <= w_db.zero;
      input_exc <= w_exc;
    end
  end
endmodule

// File: tb/tb_fpmult_unpack.sv
// Directed bench for fpmult_unpack: reset, latency, specials, subnormals, backpressure,
// mid-stream reset and a 100-pair full-rate stream checked against a reference decode.
module tb_fpmult_unpack;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        sa, sb, sp;
  logic [4:0]  ea, eb;
  logic [10:0] ma, mb;
  logic [6:0]  esum;
  logic        za, zb;
  logic [4:0]  input_exc;

  logic [48:0] exp_q[$];
  logic [48:0] obs;
  int          n_total = 0;
  int          n_bad   = 0;
  int          n_out   = 0;
  int          cyc     = 0;

  fpmult_unpack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sa(sa), .sb(sb), .sp(sp), .ea(ea), .eb(eb), .ma(ma), .mb(mb),
    .esum(esum), .za(za), .zb(zb), .input_exc(input_exc)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {sa, sb, sp, ea, eb, ma, mb, esum, za, zb, input_exc};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [48:0] mk(input logic s_a, s_b, input logic [4:0] e_a, e_b,
                                     input logic [10:0] m_a, m_b, input logic [6:0] es,
                                     input logic z_a, z_b, input logic [4:0] x);
    return {s_a, s_b, s_a ^ s_b, e_a, e_b, m_a, m_b, es, z_a, z_b, x};
  endfunction

  typedef struct packed {
    logic [4:0]  e;
    logic [10:0] m;
    logic        z;
    logic        inf;
    logic        nan;
  } rop_t;

  function automatic rop_t ref_op(input logic [15:0] x);
    rop_t        r;
    logic [4:0]  ex;
    logic [9:0]  fr;
    ex = x[14:10];
    fr = x[9:0];
    r  = '0;
    if (ex == 5'd31) begin
      r.e = 5'd31; r.m = {1'b1, fr}; r.inf = (fr == 10'd0); r.nan = (fr != 10'd0);
    end else if (ex == 5'd0 && fr == 10'd0) begin
      r.z = 1'b1;
    end else if (ex == 5'd0) begin
`ifdef FPMULT_DENORM_EN
      r.e = 5'd1; r.m = {1'b0, fr};
`else
      r.z = 1'b1;
`endif
    end else begin
      r.e = ex; r.m = {1'b1, fr};
    end
    return r;
  endfunction

  function automatic logic [48:0] ref_dec(input logic [15:0] x, input logic [15:0] y);
    rop_t ra, rb;
    int   s;
    logic inv;
    ra  = ref_op(x);
    rb  = ref_op(y);
    s   = int'(ra.e) + int'(rb.e) - 15;
    inv = ra.nan | rb.nan | (ra.inf & rb.z) | (rb.inf & ra.z);
    return mk(x[15], y[15], ra.e, rb.e, ra.m, rb.m, 7'(s), ra.z, rb.z,
              {inv, ra.nan, rb.nan, ra.inf, rb.inf});
  endfunction

  // driver: present a pair until accepted, then push its expected result
  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic [48:0] e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc) exp_q.push_back(e);
    else chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every transferred result must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("out", obs, exp_q.pop_front());
    end
  end

  logic [48:0] p1_exp, p2_exp, p3_exp;
  int          t0, n0;
  logic [15:0] ra_v, rb_v;

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 16'h3C00; b = 16'h3C00; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", obs, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_ignore_in", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // normal pair with latency check
    send(16'h3C00, 16'hC000, mk(0, 1, 5'd15, 5'd16, 11'h400, 11'h400, 7'd16, 0, 0, 5'b00000));
    @(negedge clk);
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", out_valid, 1);
    chk("lat_sp", sp, 1);
    @(posedge clk);
    #1;

    // specials, zeros and exponent extremes
    send(16'h7C00, 16'h0000, mk(0, 0, 5'd31, 5'd0, 11'h400, 11'h000, 7'd16, 0, 1, 5'b10010));
    send(16'h7E00, 16'h3C00, mk(0, 0, 5'd31, 5'd15, 11'h600, 11'h400, 7'd31, 0, 0, 5'b11000));
    send(16'h0000, 16'hFC00, mk(0, 1, 5'd0, 5'd31, 11'h000, 11'h400, 7'd16, 1, 0, 5'b10001));
    send(16'h3C00, 16'h7C01, mk(0, 0, 5'd15, 5'd31, 11'h400, 11'h401, 7'd31, 0, 0, 5'b10100));
    send(16'h8000, 16'h3C00, mk(1, 0, 5'd0, 5'd15, 11'h000, 11'h400, 7'd0, 1, 0, 5'b00000));
    send(16'h0000, 16'h0000, mk(0, 0, 5'd0, 5'd0, 11'h000, 11'h000, 7'h71, 1, 1, 5'b00000));
    send(16'h7BFF, 16'h7BFF, mk(0, 0, 5'd30, 5'd30, 11'h7FF, 11'h7FF, 7'd45, 0, 0, 5'b00000));
`ifdef FPMULT_DENORM_EN
    send(16'h0001, 16'h3C00, mk(0, 0, 5'd1, 5'd15, 11'h001, 11'h400, 7'd1, 0, 0, 5'b00000));
`else
    send(16'h0001, 16'h3C00, mk(0, 0, 5'd0, 5'd15, 11'h000, 11'h400, 7'd0, 1, 0, 5'b00000));
`endif
    drain();

    // backpressure: out_ready low during cycles 2..5 of the stream
    p1_exp = mk(0, 0, 5'd15, 5'd16, 11'h400, 11'h400, 7'd16, 0, 0, 5'b00000);
    p2_exp = mk(0, 0, 5'd16, 5'd14, 11'h600, 11'h400, 7'd15, 0, 0, 5'b00000);
    p3_exp = mk(1, 1, 5'd17, 5'd17, 11'h400, 11'h400, 7'd19, 0, 0, 5'b00000);
    n0 = n_out;
    fork
      begin
        send(16'h3C00, 16'h4000, p1_exp);
        send(16'h4200, 16'h3800, p2_exp);
        send(16'hC400, 16'hC400, p3_exp);
      end
      begin
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_valid", out_valid, 1);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold", obs, p1_exp);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - n0, 3);

    // reset with two pairs in flight
    out_ready = 1'b0;
    send(16'h4000, 16'h4000, 49'd0);
    send(16'h4400, 16'h4400, 49'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    n0 = n_out;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mid_rst_no_out", out_valid, 0);
    end
    chk("mid_rst_count", n_out - n0, 0);
    @(posedge clk);
    #1;

    // full-rate random stream
    out_ready = 1'b1;
    n0 = n_out;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      ra_v = 16'($urandom_range(0, 65535));
      rb_v = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 5) == 0) ra_v[14:10] = 5'd0;
      if ($urandom_range(0, 5) == 0) rb_v[14:10] = 5'd31;
      if ($urandom_range(0, 7) == 0) ra_v[9:0] = 10'd0;
      send(ra_v, rb_v, ref_dec(ra_v, rb_v));
    end
    chk("tput_cycles", cyc - t0, 100);
    drain();
    chk("tput_count", n_out - n0, 100);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
